// File: rtl/segre_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : segre_mem_responder
// Description : Main-memory responder on the shared cache request bus. Takes
//               one request at a time, waits a fixed latency, performs the
//               line read or write on an internal store and returns a
//               one-cycle response to the requesting cache (IC or DC).
// Revision    : 1.0 - initial release
// ============================================================================
module segre_mem_responder #(
  parameter int LATENCY    = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  mem_req_i,
  input  logic                  mem_sel_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [LINE_WIDTH-1:0] mem_wdata_i,
  output logic                  ic_rsp_valid_o,
  output logic                  dc_rsp_valid_o,
  output logic [LINE_WIDTH-1:0] mem_rdata_o,
  output logic                  busy_o
);

  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int IDX_BITS    = $clog2(DEPTH);
  localparam int CNT_W       = $clog2(LATENCY + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sel;
  logic                  r_we;
  logic [IDX_BITS-1:0]   r_idx;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_mem [DEPTH];

  // Offset bits and bits above the index take no part in addressing.
  logic w_unused_addr;
  assign w_unused_addr = ^mem_addr_i;

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk_i) begin
    if (rsn_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: capture, count down, one RESP cycle, one DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_req_i) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) w_next = S_RESP;
      end
      S_RESP:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture and latency counter; bus is only sampled in IDLE.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_req_i) begin
            r_sel   <= mem_sel_i;
            r_we    <= mem_we_i;
            r_idx   <= mem_addr_i[OFFSET_BITS +: IDX_BITS];
            r_wdata <= mem_wdata_i;
            r_cnt   <= CNT_W'(LATENCY - 1);
          end
        end
        S_WAIT:  r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Backing store (not reset); a write commits at the end of RESP unless reset hits.
  always_ff @(posedge clk_i) begin
    if (!rsn_i && (r_state == S_RESP) && r_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Outputs: response pulse and data only during RESP, zero otherwise.
  always_comb begin
    ic_rsp_valid_o = 1'b0;
    dc_rsp_valid_o = 1'b0;
    mem_rdata_o    = '0;
    busy_o         = (r_state != S_IDLE);
    if (r_state == S_RESP) begin
      ic_rsp_valid_o = ~r_sel;
      dc_rsp_valid_o = r_sel;
      mem_rdata_o    = r_we ? r_wdata : r_mem[r_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segre_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_segre_mem_responder
// Description : Self-checking bench for segre_mem_responder: directed vector
//               table, corner-case sequences and randomized transactions
//               against a line-indexed memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segre_mem_responder;

  localparam int LAT = 5;
  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int DEP = 1024;

  logic          clk_i = 1'b0;
  logic          rsn_i;
  logic          mem_req_i;
  logic          mem_sel_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [LW-1:0] mem_wdata_i;
  logic          ic_rsp_valid_o;
  logic          dc_rsp_valid_o;
  logic [LW-1:0] mem_rdata_o;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: line contents keyed by line index (addr / 16 mod DEPTH).
  logic [LW-1:0] model [int];

  segre_mem_responder #(
    .LATENCY    (LAT),
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .DEPTH      (DEP)
  ) dut (
    .clk_i          (clk_i),
    .rsn_i          (rsn_i),
    .mem_req_i      (mem_req_i),
    .mem_sel_i      (mem_sel_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .ic_rsp_valid_o (ic_rsp_valid_o),
    .dc_rsp_valid_o (dc_rsp_valid_o),
    .mem_rdata_o    (mem_rdata_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / 16) % DEP);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm, input bit exp_busy);
    chk({nm, ".ic"},    LW'(ic_rsp_valid_o), '0);
    chk({nm, ".dc"},    LW'(dc_rsp_valid_o), '0);
    chk({nm, ".rdata"}, mem_rdata_o, '0);
    chk({nm, ".busy"},  LW'(busy_o), LW'(exp_busy));
  endtask

  // One transaction from IDLE: drive, capture, then observe every cycle
  // until the block is back in IDLE. Response expected exactly LAT cycles
  // after the capture cycle on the requester's channel only.
  task automatic do_txn(input string nm, input logic sel, input logic we,
                        input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                        input logic [LW-1:0] exp, input bit hold, input bit change);
    string s;
    mem_req_i   = 1'b1;
    mem_sel_i   = sel;
    mem_we_i    = we;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    tick();
    for (int j = 1; j <= LAT + 2; j++) begin
      s = $sformatf("%s.c%0d", nm, j);
      chk({s, ".ic"},    LW'(ic_rsp_valid_o), LW'((j == LAT) && !sel));
      chk({s, ".dc"},    LW'(dc_rsp_valid_o), LW'((j == LAT) && sel));
      chk({s, ".rdata"}, mem_rdata_o, (j == LAT) ? exp : '0);
      chk({s, ".busy"},  LW'(busy_o), LW'(j <= LAT + 1));
      if (j == 1 && !hold) mem_req_i = 1'b0;
      if (j == LAT && hold) mem_req_i = 1'b0;
      if (j == 1 && change) begin
        mem_addr_i  = 32'h20;
        mem_sel_i   = ~sel;
        mem_wdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
      if (j < LAT + 2) tick();
    end
    if (we) model[line_of(addr)] = wdata;
  endtask

  typedef struct {
    logic          sel;
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  localparam logic [LW-1:0] A5 = {16{8'hA5}};
  localparam logic [LW-1:0] D1 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [LW-1:0] D2 = 128'hdeadbeefcafef00d_5555aaaa3333cccc;

  initial begin
    logic          r_sel, r_we;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_wd, r_exp;
    int            r_line;
    bit            r_hold, r_chg;

    vecs[0] = '{1'b1, 1'b1, 32'h0000_0030, A5,       A5};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0030, '0,       A5};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0040, 128'h1234, 128'h1234};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0040, '0,       128'h1234};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0010, D1,       D1};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0020, D2,       D2};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0000, 128'hCAFE, 128'hCAFE};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_4000, '0,       128'hCAFE};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_403F, '0,       A5};
    vecs[9] = '{1'b0, 1'b1, 32'h0000_0050, 128'h0BAD, 128'h0BAD};

    rsn_i       = 1'b1;
    mem_req_i   = 1'b0;
    mem_sel_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    tick();
    tick();
    chk_quiet("reset", 1'b0);
    rsn_i = 1'b0;
    tick();
    chk_quiet("idle", 1'b0);

    for (int i = 0; i < 10; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].sel, vecs[i].we, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp, 1'b0, 1'b0);
    end

    // Request held through RESP, dropped during DONE: served once only.
    do_txn("held", 1'b0, 1'b0, 32'h40, '0, 128'h1234, 1'b1, 1'b0);
    chk_quiet("held.after", 1'b0);

    // Bus changes during WAIT must not alter the captured read.
    do_txn("buschg", 1'b0, 1'b0, 32'h10, '0, D1, 1'b0, 1'b1);

    // Reset two cycles after capturing a write: dropped and not committed.
    mem_req_i   = 1'b1;
    mem_sel_i   = 1'b0;
    mem_we_i    = 1'b1;
    mem_addr_i  = 32'h50;
    mem_wdata_i = 128'hFF;
    tick();
    chk_quiet("rst.c1", 1'b1);
    mem_req_i = 1'b0;
    tick();
    chk_quiet("rst.c2", 1'b1);
    rsn_i = 1'b1;
    tick();
    chk_quiet("rst.c3", 1'b0);
    rsn_i = 1'b0;
    for (int j = 0; j < LAT + 2; j++) begin
      tick();
      chk_quiet($sformatf("rst.post%0d", j), 1'b0);
    end
    do_txn("rst.read", 1'b1, 1'b0, 32'h50, '0, 128'h0BAD, 1'b0, 1'b0);

    // Randomized traffic over 16 lines with random alias/offset bits.
    for (int i = 0; i < 150; i++) begin
      r_line = int'($urandom_range(0, 15));
      r_addr = ($urandom & 32'hFFFF_C000) | (32'(r_line) << 4) | ($urandom & 32'hF);
      r_sel  = 1'($urandom);
      r_we   = 1'($urandom);
      if (!model.exists(r_line)) r_we = 1'b1;
      r_wd   = {$urandom, $urandom, $urandom, $urandom};
      r_exp  = r_we ? r_wd : model[r_line];
      r_hold = ($urandom_range(0, 3) == 0);
      r_chg  = !r_hold && ($urandom_range(0, 3) == 0);
      do_txn($sformatf("rnd%0d", i), r_sel, r_we, r_addr, r_wd, r_exp, r_hold, r_chg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
